// File: rtl/tstate_sequencer.sv
// Microcode front end: instruction register plus the T-state counter whose
// {instr[15:8], T} pair addresses the decode ROMs.
module tstate_sequencer #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned T_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] bus_in,
    input  logic               ii,
    input  logic               rt,
    input  logic               stall,
    output logic [INSTR_W-1:0] instr,
    output logic [T_W-1:0]     T,
    output logic               fetch,
    output logic               instr_valid,
    output logic               overrun
);

    localparam logic [T_W-1:0] T_MAX       = {T_W{1'b1}};
    localparam logic [T_W-1:0] T_FETCH_END = T_W'(2);
    localparam logic [T_W-1:0] T_ONE       = T_W'(1);

    logic [T_W-1:0] t_next;
    logic           wrap;

    // Next T-state: T0/T1 are the fixed fetch uinstrs and cannot end an instr.
    always_comb begin
        t_next = T + T_ONE;
        wrap   = 1'b0;
        if (T < T_FETCH_END) begin
            t_next = T + T_ONE;
        end else if (rt) begin
            t_next = '0;
        end else if (T == T_MAX) begin
            t_next = '0;
            wrap   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            T           <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (!stall) begin
            T <= t_next;
            if (wrap) begin
                overrun <= 1'b1;
            end
            if (ii) begin
                instr       <= bus_in;
                instr_valid <= 1'b1;
            end
        end
    end

    // Fetch flag follows T directly so the ROM mux can select the fixed uinstrs.
    assign fetch = (T < T_FETCH_END);

endmodule

// File: tb/tb_tstate_sequencer.sv
// Self-checking bench for tstate_sequencer: directed scenarios plus random
// stimulus against a behavioural model of the T-state rules.
module tb_tstate_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic        ii, rt, stall;
    logic [15:0] instr;
    logic [2:0]  T;
    logic        fetch, instr_valid, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int          m_t;
    logic [15:0] m_instr;
    bit          m_valid;
    bit          m_ovr;

    tstate_sequencer dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .ii(ii), .rt(rt),
        .stall(stall), .instr(instr), .T(T), .fetch(fetch),
        .instr_valid(instr_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".T"}, 32'(T), 32'(m_t));
        check({tag, ".instr"}, 32'(instr), 32'(m_instr));
        check({tag, ".valid"}, 32'(instr_valid), 32'(m_valid));
        check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
        check({tag, ".fetch"}, 32'(fetch), 32'(m_t < 2));
    endtask

    // Model of one rising edge; counting is modulo 8 and a wrap without RT is an overrun.
    task automatic model_edge(input bit i_ii, input bit i_rt, input bit i_st, input logic [15:0] bus);
        if (i_st) return;
        if (m_t >= 2 && i_rt) begin
            m_t = 0;
        end else begin
            if (m_t == 7) m_ovr = 1'b1;
            m_t = (m_t + 1) % 8;
        end
        if (i_ii) begin
            m_instr = bus;
            m_valid = 1'b1;
        end
    endtask

    // Called 1 time unit after a rising edge: drive, check fetch ignores stall, clock, check.
    task automatic cyc(input bit i_ii, input bit i_rt, input bit i_st, input logic [15:0] bus);
        ii = i_ii; rt = i_rt; stall = i_st; bus_in = bus;
        #1;
        check("fetch_pre", 32'(fetch), 32'(m_t < 2));
        @(posedge clk);
        model_edge(i_ii, i_rt, i_st, bus);
        #1;
        check_all("cyc");
    endtask

    // Asynchronous reset asserted between edges, checked before the next edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        m_t = 0; m_instr = '0; m_valid = 1'b0; m_ovr = 1'b0;
        check_all("rst_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ii = 1'b0; rt = 1'b0; stall = 1'b0; bus_in = '0;
        m_t = 0; m_instr = '0; m_valid = 1'b0; m_ovr = 1'b0;
        @(posedge clk); #1;
        check_all("reset");
        reset = 1'b0;

        // reset in the middle of T4 with an instruction loaded
        cyc(0, 0, 0, 16'h0);
        cyc(1, 0, 0, 16'h1234);
        cyc(0, 0, 0, 16'h0);
        cyc(0, 0, 0, 16'h0);
        check("t1_T4", 32'(T), 32'd4);
        check("t1_instr", 32'(instr), 32'h1234);
        do_reset();
        check("t1_instr0", 32'(instr), 32'h0);

        // shortest instruction 0,1,2,0
        cyc(0, 0, 0, 16'h0);
        check("t2_T1", 32'(T), 32'd1);
        cyc(1, 0, 0, 16'hA5C3);
        check("t2_T2", 32'(T), 32'd2);
        cyc(0, 1, 0, 16'h0);
        check("t2_T0", 32'(T), 32'd0);
        check("t2_instr", 32'(instr), 32'hA5C3);
        check("t2_valid", 32'(instr_valid), 32'd1);
        check("t2_ovr", 32'(overrun), 32'd0);

        // rt ignored during fetch
        cyc(0, 1, 0, 16'h0);
        cyc(0, 1, 0, 16'h0);
        check("t3_T2", 32'(T), 32'd2);
        cyc(0, 1, 0, 16'h0);
        check("t3_T0", 32'(T), 32'd0);

        // no rt: 0..7 then wrap, overrun sticky
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 16'h0);
        check("t4_T7", 32'(T), 32'd7);
        check("t4_ovr0", 32'(overrun), 32'd0);
        cyc(0, 0, 0, 16'h0);
        check("t4_wrap", 32'(T), 32'd0);
        check("t4_ovr1", 32'(overrun), 32'd1);
        cyc(0, 0, 0, 16'h0);
        cyc(1, 0, 0, 16'h5555);
        cyc(0, 1, 0, 16'h0);
        check("t4_sticky", 32'(overrun), 32'd1);
        do_reset();
        check("t4_clr", 32'(overrun), 32'd0);

        // stall at T3 holds everything
        cyc(0, 0, 0, 16'h0);
        cyc(1, 0, 0, 16'h7E7E);
        cyc(0, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 16'hFFFF);
            check("t5_T3", 32'(T), 32'd3);
            check("t5_hold", 32'(instr), 32'h7E7E);
        end
        cyc(1, 1, 0, 16'hFFFF);
        check("t5_T0", 32'(T), 32'd0);
        check("t5_instr", 32'(instr), 32'hFFFF);

        // ii and rt together at T5
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 16'h0);
        check("t6_T5", 32'(T), 32'd5);
        cyc(1, 1, 0, 16'h0102);
        check("t6_instr", 32'(instr), 32'h0102);
        check("t6_T0", 32'(T), 32'd0);

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                cyc(1'($urandom_range(99) < 30), 1'($urandom_range(99) < 15),
                    1'($urandom_range(99) < 25), 16'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
